// File: rtl/j1_uart_io.sv
// Memory-mapped UART for the J1 I/O bus: RX/TX byte FIFOs, status register, RX interrupt.
// Latency: io_din is combinational; TX start bit begins 1 cycle after the first push; an RX byte lands 1 cycle after its stop-bit sample.
// Backpressure: none on the bus; TX writes to a full FIFO are dropped (tx_drop), RX bytes arriving at a full FIFO are dropped (rx_overrun).
module j1_uart_io #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int          CLK_HZ    = 100000000,
  parameter int          BAUD      = 115200,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rx_irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [15:0] ADDR_RX = BASE_ADDR;
  localparam logic [15:0] ADDR_TX = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_ST = BASE_ADDR + 16'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------
  logic rd_rx, rd_st, wr_tx;
  assign rd_rx = io_rd && (io_addr == ADDR_RX);
  assign rd_st = io_rd && (io_addr == ADDR_ST);
  assign wr_tx = io_wr && (io_addr == ADDR_TX);

  // Only the low byte of a TX write is transmitted.
  logic unused_dout;
  assign unused_dout = ^io_dout[15:8];

  // ---------------------------------------------------------------
  // TX FIFO: extra pointer bit distinguishes full from empty
  // ---------------------------------------------------------------
  logic [7:0]   tx_mem [0:TX_DEPTH-1];
  logic [TAW:0] tx_wp, tx_rp;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]   tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign tx_head  = tx_mem[tx_rp[TAW-1:0]];
  assign tx_push  = wr_tx && !tx_full;

  // TX FIFO pointers advance on accepted push and on FSM pop
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (TAW+1)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (TAW+1)'(1);
    end
  end

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= io_dout[7:0];
  end

  // ---------------------------------------------------------------
  // TX serialiser
  // ---------------------------------------------------------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == DIV_M1);

  // TX state register
  always_ff @(posedge clk) begin
    if (reset) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  // TX next state: back-to-back frames chain STOP straight into START
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: line level and FIFO pop when a new frame is loaded
  always_comb begin
    uart_tx = 1'b1;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:  tx_pop  = !tx_empty;
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_sh[0];
      TX_STOP:  tx_pop  = tx_tick && !tx_empty;
      default:  uart_tx = 1'b1;
    endcase
  end

  // TX datapath: baud counter, bit counter, shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + CW'(1);

      if (tx_state == TX_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
      else if (tx_state != TX_DATA)       tx_bit <= '0;

      if (tx_pop)                              tx_sh <= tx_head;
      else if (tx_state == TX_DATA && tx_tick) tx_sh <= {1'b0, tx_sh[7:1]};
    end
  end

  // ---------------------------------------------------------------
  // RX synchroniser and falling-edge detect
  // ---------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev, rx_fall;

  // Two-flop synchroniser plus one delayed copy for edge detect; idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Edge rather than level so a low stop bit cannot retrigger a frame
  assign rx_fall = rx_prev && !rx_s2;

  // ---------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------
  logic [7:0]   rx_mem [0:RX_DEPTH-1];
  logic [RAW:0] rx_wp, rx_rp;
  logic         rx_empty, rx_full, rx_push, rx_pop, rx_push_req;
  logic [7:0]   rx_head, rx_sh;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_head  = rx_mem[rx_rp[RAW-1:0]];
  assign rx_pop   = rd_rx && !rx_empty;
  // A CPU pop in the same cycle frees the slot, so a full FIFO still accepts
  assign rx_push  = rx_push_req && (!rx_full || rx_pop);
  assign rx_irq   = !rx_empty;

  // RX FIFO pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + (RAW+1)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (RAW+1)'(1);
    end
  end

  // RX FIFO storage write
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
  end

  // ---------------------------------------------------------------
  // RX deserialiser
  // ---------------------------------------------------------------
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_half, rx_tick, rx_ferr_set;

  assign rx_half = (rx_cnt == HALF_M1);
  assign rx_tick = (rx_cnt == DIV_M1);

  // RX state register
  always_ff @(posedge clk) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // RX next state: mid-start check rejects glitches, IDLE again at stop sample
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX outputs: good stop bit pushes the byte, bad one flags a framing error
  always_comb begin
    rx_push_req = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_state == RX_STOP && rx_tick) begin
      rx_push_req = rx_s2;
      rx_ferr_set = !rx_s2;
    end
  end

  // RX datapath: counter restarts at mid-start so later samples land mid-bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_state == RX_IDLE || (rx_state == RX_START && rx_half) || rx_tick)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + CW'(1);

      if (rx_state == RX_DATA && rx_tick) begin
        rx_bit <= rx_bit + 3'd1;
        rx_sh  <= {rx_s2, rx_sh[7:1]};
      end else if (rx_state != RX_DATA) begin
        rx_bit <= '0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Sticky error flags and status
  // ---------------------------------------------------------------
  logic rx_overrun, frame_err, tx_drop, tx_idle;
  logic [15:0] status;

  assign tx_idle = tx_empty && (tx_state == TX_IDLE);
  assign status  = {10'd0, tx_drop, frame_err, rx_overrun, tx_idle, tx_full, !rx_empty};

  // Sticky flags: a status read clears them, a same-cycle set wins
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      rx_overrun <= (rx_overrun && !rd_st) || (rx_push_req && !rx_push);
      frame_err  <= (frame_err  && !rd_st) || rx_ferr_set;
      tx_drop    <= (tx_drop    && !rd_st) || (wr_tx && tx_full);
    end
  end

  // Read mux: zero whenever nothing readable is selected
  always_comb begin
    io_din = 16'h0000;
    if (rd_rx && !rx_empty) io_din = {8'h00, rx_head};
    else if (rd_st)         io_din = status;
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// Directed bench for j1_uart_io at DIV=12 (12 MHz clock, 1 Mbaud).
// Drives the J1 bus and the serial input, decodes the serial output in the background.
// Expected values are hand-derived from the bus/line behaviour of the peripheral.
module tb_j1_uart_io;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_dout = 16'h0000;
  logic [15:0] io_din;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        rx_irq;

  localparam int DIV = 12;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Decoded TX frames as {stop, data}
  logic [8:0] tx_seen [$];

  always #5 clk = ~clk;

  j1_uart_io #(
    .BASE_ADDR(16'h4000),
    .CLK_HZ   (12000000),
    .BAUD     (1000000),
    .TX_DEPTH (16),
    .RX_DEPTH (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_rd  (io_rd),
    .io_wr  (io_wr),
    .io_addr(io_addr),
    .io_dout(io_dout),
    .io_din (io_din),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .rx_irq (rx_irq)
  );

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; io_addr = a; io_dout = d;
    tick();
    io_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    io_rd = 1'b1; io_addr = a;
    #1;
    d = io_din;
    tick();
    io_rd = 1'b0;
  endtask

  // Look at io_din with io_rd high but drop it before any clock edge: no side effects
  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    io_rd = 1'b1; io_addr = a;
    #1;
    d = io_din;
    io_rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (DIV) tick();
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (DIV) tick();
    end
    uart_rx = stop;
    repeat (DIV) tick();
    uart_rx = 1'b1;
  endtask

  // Background serial decoder: samples each bit near its middle
  initial begin
    logic [8:0] fr;
    forever begin
      @(negedge uart_tx);
      repeat (DIV/2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(negedge clk);
        fr[k] = uart_tx;
      end
      repeat (DIV) @(negedge clk);
      fr[8] = uart_tx;
      tx_seen.push_back(fr);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    logic [9:0]  tx_exp;
    logic [7:0]  exp_b;

    // ---- reset state ----
    repeat (3) tick();
    check_val("rst_uart_tx", 16'(uart_tx), 16'h0001);
    check_val("rst_rx_irq", 16'(rx_irq), 16'h0000);
    check_val("rst_io_din", io_din, 16'h0000);
    reset = 1'b0;
    tick();
    peek(16'h4002, v); check_val("rst_status", v, 16'h0004);
    peek(16'h4000, v); check_val("rst_rx_empty_rd", v, 16'h0000);

    // ---- ignored writes and unmapped reads ----
    bus_wr(16'h4000, 16'h0099);
    bus_wr(16'h4002, 16'h00FF);
    bus_wr(16'h4005, 16'h0011);
    tick();
    peek(16'h4002, v); check_val("ign_wr_status", v, 16'h0004);
    peek(16'h4003, v); check_val("unmapped_rd", v, 16'h0000);
    io_addr = 16'h4002; #1;
    check_val("no_strobe_din", io_din, 16'h0000);
    check_val("ign_uart_tx", 16'(uart_tx), 16'h0001);

    // ---- single TX frame 0x41 ----
    tx_seen.delete();
    tx_exp = 10'b1_0100_0001_0;   // stop, data MSB..LSB, start
    bus_wr(16'h4001, 16'h0041);
    check_val("tx41_pre", 16'(uart_tx), 16'h0001);
    tick();
    check_val("tx41_start_edge", 16'(uart_tx), 16'h0000);
    repeat (DIV/2) tick();
    check_val("tx41_bit0", 16'(uart_tx), 16'(tx_exp[0]));
    for (int k = 1; k < 10; k++) begin
      repeat (DIV) tick();
      check_val($sformatf("tx41_bit%0d", k), 16'(uart_tx), 16'(tx_exp[k]));
    end
    repeat (5) tick();
    peek(16'h4002, v); check_val("tx41_busy_end", v, 16'h0000);
    tick();
    peek(16'h4002, v); check_val("tx41_idle", v, 16'h0004);
    check_val("tx41_nframes", 16'(tx_seen.size()), 16'd1);
    check_val("tx41_decoded", 16'(tx_seen[0]), 16'h0141);

    // ---- 17-byte burst behind a frame already in flight ----
    tx_seen.delete();
    bus_wr(16'h4001, 16'h00A5);
    tick();
    for (int i = 0; i < 17; i++) bus_wr(16'h4001, 16'h0010 + 16'(i));
    peek(16'h4002, v); check_val("burst_status", v, 16'h0022);
    bus_rd(16'h4002, v); check_val("burst_status_rd", v, 16'h0022);
    peek(16'h4002, v); check_val("burst_status_clr", v, 16'h0002);
    // 17 frames of 120 cycles with no gap end exactly 2040 cycles after the start bit
    repeat (2021) tick();
    peek(16'h4002, v); check_val("burst_busy_end", v, 16'h0000);
    tick();
    peek(16'h4002, v); check_val("burst_drained", v, 16'h0004);
    check_val("burst_nframes", 16'(tx_seen.size()), 16'd17);
    for (int i = 0; i < 17; i++) begin
      exp_b = (i == 0) ? 8'hA5 : 8'(8'h10 + i - 1);
      check_val($sformatf("burst_frame%0d", i), 16'(tx_seen[i]), {7'd0, 1'b1, exp_b});
    end

    // ---- single RX frame 0x5A ----
    send_rx(8'h5A, 1'b1);
    tick();
    check_val("rx5a_irq", 16'(rx_irq), 16'h0001);
    peek(16'h4002, v); check_val("rx5a_status", v, 16'h0005);
    bus_rd(16'h4000, v); check_val("rx5a_data", v, 16'h005A);
    check_val("rx5a_irq_clr", 16'(rx_irq), 16'h0000);
    bus_rd(16'h4000, v); check_val("rx5a_empty_rd", v, 16'h0000);

    // ---- RX overrun: 17 frames, nothing read ----
    for (int i = 0; i < 17; i++) send_rx(8'h30 + 8'(i), 1'b1);
    tick();
    peek(16'h4002, v); check_val("ovr_status", v, 16'h000D);
    for (int i = 0; i < 16; i++) begin
      bus_rd(16'h4000, v);
      check_val($sformatf("ovr_data%0d", i), v, 16'h0030 + 16'(i));
    end
    check_val("ovr_irq_clr", 16'(rx_irq), 16'h0000);
    bus_rd(16'h4002, v); check_val("ovr_status_rd", v, 16'h000C);
    peek(16'h4002, v); check_val("ovr_status_clr", v, 16'h0004);

    // ---- framing error, then recovery ----
    send_rx(8'h77, 1'b0);
    repeat (24) tick();
    check_val("ferr_irq", 16'(rx_irq), 16'h0000);
    bus_rd(16'h4002, v); check_val("ferr_status_rd", v, 16'h0014);
    peek(16'h4002, v); check_val("ferr_status_clr", v, 16'h0004);
    send_rx(8'h3C, 1'b1);
    tick();
    bus_rd(16'h4000, v); check_val("ferr_recover", v, 16'h003C);

    // ---- 4-cycle glitch is rejected ----
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (150) tick();
    check_val("glitch_irq", 16'(rx_irq), 16'h0000);
    peek(16'h4002, v); check_val("glitch_status", v, 16'h0004);

    // ---- reset in the middle of a TX frame (0x55, data bit 1 is low) ----
    bus_wr(16'h4001, 16'h0055);
    tick();
    repeat (29) tick();
    check_val("rst_mid_low", 16'(uart_tx), 16'h0000);
    reset = 1'b1;
    tick();
    check_val("rst_mid_tx_high", 16'(uart_tx), 16'h0001);
    tick();
    reset = 1'b0;
    tick();
    peek(16'h4002, v); check_val("rst_mid_status", v, 16'h0004);
    repeat (3 * DIV) tick();
    check_val("rst_mid_stays_high", 16'(uart_tx), 16'h0001);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
